regdesp_n: RTL and testbench

Parametrised W-bit load/shift register, the next generation of the Booth-datapath accumulator register. Adds selectable shift modes, a serial input for chaining two instances into an A:Q pair, and an autonomous multi-step shift sequencer with busy/done handshake. It sits in the multiplier datapath under control of the control unit (UC).

---
 rtl/regdesp_n_if.sv | 29 ++
 rtl/regdesp_n.sv | 110 +++++++++++
 tb/tb_regdesp_n.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regdesp_n_if.sv
// Control/data bundle of the regdesp_n load/shift register.
// The UC side drives the master modport and the register sits on the slave modport.
interface regdesp_n_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 4
);
    logic          Carga;
    logic [W-1:0]  Ent;
    logic          Desplaza;
    logic [1:0]    Modo;
    logic          SerIn;
    logic          Inicio;
    logic [CW-1:0] Cuenta;
    logic [W-1:0]  q;
    logic          BitBajo;
    logic          BitAlto;
    logic          Ocupado;
    logic          Fin;

    modport master (
        output Carga, Ent, Desplaza, Modo, SerIn, Inicio, Cuenta,
        input  q, BitBajo, BitAlto, Ocupado, Fin
    );

    modport slave (
        input  Carga, Ent, Desplaza, Modo, SerIn, Inicio, Cuenta,
        output q, BitBajo, BitAlto, Ocupado, Fin
    );
endinterface

// File: rtl/regdesp_n.sv
// W-bit load/shift register for the Booth datapath.
// It supports four shift modes, a serial input for A:Q chaining and a multi-step shift sequencer.
module regdesp_n #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 4
) (
    input  logic        clk,
    input  logic        Reset,
    regdesp_n_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] MODO_ASR = 2'b00;
    localparam logic [1:0] MODO_LSR = 2'b01;
    localparam logic [1:0] MODO_SHL = 2'b10;
    localparam logic [1:0] MODO_ROR = 2'b11;

    state_t        state, state_d;
    logic [W-1:0]  q_r, q_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0]    modo_r, modo_d;
    logic          ocupado_r, ocupado_d;
    logic          fin_r, fin_d;

    // One-bit shift of the current contents in the selected mode
    function automatic logic [W-1:0] shift1(input logic [W-1:0] v,
                                            input logic [1:0]   m,
                                            input logic         s);
        logic [W-1:0] r;
        case (m)
            MODO_ASR: r = {v[W-1], v[W-1:1]};
            MODO_LSR: r = {s, v[W-1:1]};
            MODO_SHL: r = {v[W-2:0], s};
            MODO_ROR: r = {v[0], v[W-1:1]};
            default:  r = v;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            q_r       <= '0;
            cnt       <= '0;
            modo_r    <= MODO_ASR;
            ocupado_r <= 1'b0;
            fin_r     <= 1'b0;
        end else begin
            state     <= state_d;
            q_r       <= q_d;
            cnt       <= cnt_d;
            modo_r    <= modo_d;
            ocupado_r <= ocupado_d;
            fin_r     <= fin_d;
        end
    end

    // Next state: a load beats the sequencer, and the sequencer beats any new Inicio or Desplaza
    always_comb begin
        state_d = state;
        q_d     = q_r;
        cnt_d   = cnt;
        modo_d  = modo_r;
        fin_d   = 1'b0;

        if (bus.Carga) begin
            q_d     = bus.Ent;
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                SHIFT: begin
                    q_d   = shift1(q_r, modo_r, bus.SerIn);
                    cnt_d = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_d = IDLE;
                        fin_d   = 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.Inicio) begin
                        if (bus.Cuenta == '0) begin
                            fin_d = 1'b1;
                        end else begin
                            cnt_d   = bus.Cuenta;
                            modo_d  = bus.Modo;
                            state_d = SHIFT;
                        end
                    end else if (bus.Desplaza) begin
                        q_d = shift1(q_r, bus.Modo, bus.SerIn);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        ocupado_d = (state_d == SHIFT);
    end

    assign bus.q       = q_r;
    assign bus.Ocupado = ocupado_r;
    assign bus.Fin     = fin_r;
    assign bus.BitBajo = q_r[0];
    assign bus.BitAlto = q_r[W-1];

endmodule

// File: tb/tb_regdesp_n.sv
// Directed self-checking bench for regdesp_n, including an A:Q chained pair.
module tb_regdesp_n;
    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    regdesp_n_if #(.W(W), .CW(CW)) ba ();
    regdesp_n_if #(.W(W), .CW(CW)) bq ();

    regdesp_n #(.W(W), .CW(CW)) dut   (.clk(clk), .Reset(Reset), .bus(ba));
    regdesp_n #(.W(W), .CW(CW)) dut_q (.clk(clk), .Reset(Reset), .bus(bq));

    assign bq.SerIn = ba.BitBajo;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ba.Carga = 0; ba.Ent = '0; ba.Desplaza = 0; ba.Modo = 2'b00;
        ba.SerIn = 0; ba.Inicio = 0; ba.Cuenta = '0;
        bq.Carga = 0; bq.Ent = '0; bq.Desplaza = 0; bq.Modo = 2'b00;
        bq.Inicio = 0; bq.Cuenta = '0;
    endtask

    task automatic load(input logic [W-1:0] v);
        ba.Carga = 1; ba.Ent = v;
        tick();
        ba.Carga = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1;
        #12;
        checks++;
        if (ba.q !== 8'h00 || ba.Ocupado !== 1'b0 || ba.Fin !== 1'b0) begin
            errors++;
            $display("FAIL reset: q=%h ocup=%b fin=%b, want 00/0/0", ba.q, ba.Ocupado, ba.Fin);
        end
        checks++;
        if (ba.BitBajo !== 1'b0 || ba.BitAlto !== 1'b0) begin
            errors++;
            $display("FAIL reset_bits: lo=%b hi=%b, want 0/0", ba.BitBajo, ba.BitAlto);
        end
        @(negedge clk);
        Reset = 0;
    endtask

    task automatic test_asr();
        logic [W-1:0] exp_v [4];
        exp_v[0] = 8'hB4; exp_v[1] = 8'hDA; exp_v[2] = 8'hED; exp_v[3] = 8'hF6;
        load(8'hB4);
        checks++;
        if (ba.q !== exp_v[0]) begin
            errors++; $display("FAIL asr_load: q=%h want %h", ba.q, exp_v[0]);
        end
        ba.Modo = 2'b00; ba.Desplaza = 1;
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++;
            if (ba.q !== exp_v[i]) begin
                errors++; $display("FAIL asr_step%0d: q=%h want %h", i, ba.q, exp_v[i]);
            end
        end
        ba.Desplaza = 0;
    endtask

    task automatic test_modes();
        load(8'h96);
        ba.Desplaza = 1; ba.Modo = 2'b01; ba.SerIn = 1;
        tick();
        checks++;
        if (ba.q !== 8'hCB) begin errors++; $display("FAIL lsr: q=%h want cb", ba.q); end
        ba.Modo = 2'b10; ba.SerIn = 1;
        tick();
        checks++;
        if (ba.q !== 8'h97) begin errors++; $display("FAIL shl: q=%h want 97", ba.q); end
        ba.Modo = 2'b11; ba.SerIn = 0;
        tick();
        checks++;
        if (ba.q !== 8'hCB || ba.BitAlto !== 1'b1 || ba.BitBajo !== 1'b1) begin
            errors++; $display("FAIL ror: q=%h hi=%b lo=%b want cb/1/1", ba.q, ba.BitAlto, ba.BitBajo);
        end
        ba.Desplaza = 0;
    endtask

    task automatic test_seq_ror();
        int ocup_n = 0, fin_n = 0;
        logic [W-1:0] q_at_fin = '0;
        load(8'h81);
        ba.Inicio = 1; ba.Cuenta = 4'd3; ba.Modo = 2'b11;
        tick();
        ba.Inicio = 0; ba.Modo = 2'b00;
        for (int i = 0; i < 8; i++) begin
            if (ba.Ocupado === 1'b1) ocup_n++;
            if (ba.Fin === 1'b1) begin fin_n++; q_at_fin = ba.q; end
            tick();
        end
        checks++;
        if (ocup_n != 3) begin errors++; $display("FAIL seq_ocupado: cycles=%0d want 3", ocup_n); end
        checks++;
        if (fin_n != 1) begin errors++; $display("FAIL seq_fin: pulses=%0d want 1", fin_n); end
        checks++;
        if (q_at_fin !== 8'h30 || ba.q !== 8'h30) begin
            errors++; $display("FAIL seq_q: at_fin=%h now=%h want 30", q_at_fin, ba.q);
        end
    endtask

    task automatic test_zero_count();
        load(8'h3C);
        ba.Inicio = 1; ba.Cuenta = 4'd0;
        tick();
        ba.Inicio = 0;
        checks++;
        if (ba.Fin !== 1'b1 || ba.Ocupado !== 1'b0 || ba.q !== 8'h3C) begin
            errors++; $display("FAIL zero_fin: fin=%b ocup=%b q=%h want 1/0/3c", ba.Fin, ba.Ocupado, ba.q);
        end
        tick();
        checks++;
        if (ba.Fin !== 1'b0 || ba.Ocupado !== 1'b0) begin
            errors++; $display("FAIL zero_after: fin=%b ocup=%b want 0/0", ba.Fin, ba.Ocupado);
        end
    endtask

    task automatic test_saturate();
        int n = 0;
        bit seen = 0;
        load(8'h80);
        ba.Inicio = 1; ba.Cuenta = 4'd10; ba.Modo = 2'b00;
        tick();
        ba.Inicio = 0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (ba.Fin === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || n != 10 || ba.q !== 8'hFF) begin
            errors++; $display("FAIL saturate: seen=%0d cycles=%0d q=%h want 1/10/ff", seen, n, ba.q);
        end
    endtask

    task automatic test_abort();
        int fin_n = 0;
        load(8'h0F);
        ba.Inicio = 1; ba.Cuenta = 4'd5; ba.Modo = 2'b11;
        tick();
        ba.Inicio = 0;
        tick();
        ba.Carga = 1; ba.Ent = 8'h5A;
        tick();
        ba.Carga = 0;
        checks++;
        if (ba.q !== 8'h5A || ba.Ocupado !== 1'b0 || ba.Fin !== 1'b0) begin
            errors++; $display("FAIL abort: q=%h ocup=%b fin=%b want 5a/0/0", ba.q, ba.Ocupado, ba.Fin);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ba.Fin === 1'b1) fin_n++;
        end
        checks++;
        if (fin_n != 0 || ba.q !== 8'h5A) begin
            errors++; $display("FAIL abort_after: fin=%0d q=%h want 0/5a", fin_n, ba.q);
        end
    endtask

    task automatic test_ignore_busy();
        load(8'h81);
        ba.Inicio = 1; ba.Cuenta = 4'd2; ba.Modo = 2'b11;
        tick();
        ba.Desplaza = 1; ba.Inicio = 1; ba.Cuenta = 4'd5; ba.Modo = 2'b00;
        tick();
        checks++;
        if (ba.q !== 8'hC0 || ba.Ocupado !== 1'b1) begin
            errors++; $display("FAIL busy_step: q=%h ocup=%b want c0/1", ba.q, ba.Ocupado);
        end
        tick();
        ba.Desplaza = 0; ba.Inicio = 0;
        checks++;
        if (ba.q !== 8'h60 || ba.Fin !== 1'b1 || ba.Ocupado !== 1'b0) begin
            errors++; $display("FAIL busy_end: q=%h fin=%b ocup=%b want 60/1/0", ba.q, ba.Fin, ba.Ocupado);
        end
    endtask

    task automatic test_priority();
        ba.Carga = 1; ba.Ent = 8'h55; ba.Inicio = 1; ba.Cuenta = 4'd3;
        tick();
        ba.Carga = 0; ba.Inicio = 0;
        checks++;
        if (ba.q !== 8'h55 || ba.Ocupado !== 1'b0) begin
            errors++; $display("FAIL load_inicio: q=%h ocup=%b want 55/0", ba.q, ba.Ocupado);
        end
        tick();
        checks++;
        if (ba.Fin !== 1'b0 || ba.Ocupado !== 1'b0 || ba.q !== 8'h55) begin
            errors++; $display("FAIL load_inicio_after: fin=%b ocup=%b q=%h want 0/0/55", ba.Fin, ba.Ocupado, ba.q);
        end
        ba.Desplaza = 1; ba.Inicio = 1; ba.Cuenta = 4'd1; ba.Modo = 2'b11;
        tick();
        ba.Desplaza = 0; ba.Inicio = 0;
        checks++;
        if (ba.q !== 8'h55 || ba.Ocupado !== 1'b1) begin
            errors++; $display("FAIL desp_inicio: q=%h ocup=%b want 55/1", ba.q, ba.Ocupado);
        end
        tick();
        checks++;
        if (ba.q !== 8'hAA || ba.Fin !== 1'b1) begin
            errors++; $display("FAIL desp_inicio_end: q=%h fin=%b want aa/1", ba.q, ba.Fin);
        end
    endtask

    task automatic test_back_to_back();
        int fin_n = 0;
        load(8'h01);
        ba.Inicio = 1; ba.Cuenta = 4'd1; ba.Modo = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ba.Fin === 1'b1) fin_n++;
        end
        ba.Inicio = 0;
        checks++;
        if (fin_n != 2 || ba.q !== 8'h40) begin
            errors++; $display("FAIL back_to_back: fins=%0d q=%h want 2/40", fin_n, ba.q);
        end
        tick();
    endtask

    task automatic test_chain();
        ba.Carga = 1; ba.Ent = 8'h01; bq.Carga = 1; bq.Ent = 8'h00;
        tick();
        ba.Carga = 0; bq.Carga = 0;
        ba.Modo = 2'b01; bq.Modo = 2'b01; ba.SerIn = 0;
        ba.Desplaza = 1; bq.Desplaza = 1;
        tick();
        ba.Desplaza = 0; bq.Desplaza = 0;
        checks++;
        if (ba.q !== 8'h00 || bq.q !== 8'h80) begin
            errors++; $display("FAIL chain: A=%h Q=%h want 00/80", ba.q, bq.q);
        end
    endtask

    task automatic test_async_reset();
        int fin_n = 0;
        load(8'hF0);
        ba.Inicio = 1; ba.Cuenta = 4'd4; ba.Modo = 2'b00;
        tick();
        ba.Inicio = 0;
        tick();
        #2 Reset = 1;
        #1;
        checks++;
        if (ba.q !== 8'h00 || ba.Ocupado !== 1'b0 || ba.Fin !== 1'b0) begin
            errors++; $display("FAIL async_reset: q=%h ocup=%b fin=%b want 00/0/0", ba.q, ba.Ocupado, ba.Fin);
        end
        #1 Reset = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ba.Fin === 1'b1 || ba.Ocupado === 1'b1) fin_n++;
        end
        checks++;
        if (fin_n != 0) begin errors++; $display("FAIL reset_quiet: active cycles=%0d want 0", fin_n); end
        load(8'h81);
        ba.Inicio = 1; ba.Cuenta = 4'd1; ba.Modo = 2'b11;
        tick();
        ba.Inicio = 0;
        tick();
        checks++;
        if (ba.q !== 8'hC0 || ba.Fin !== 1'b1) begin
            errors++; $display("FAIL post_reset_seq: q=%h fin=%b want c0/1", ba.q, ba.Fin);
        end
    endtask

    initial begin
        test_reset();
        test_asr();
        test_modes();
        test_seq_ror();
        test_zero_count();
        test_saturate();
        test_abort();
        test_ignore_busy();
        test_priority();
        test_back_to_back();
        test_chain();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
